// File: rtl/pin_codec_pkg.sv
// pin_pkg: shared constants for the pin codec.
//   MODE_DECOMPRESS / MODE_COMPRESS : values of the 1-bit mode input
//   state_e                         : FSM state encodings (IDLE, RUN, DONE)
package pin_pkg;

  localparam logic MODE_DECOMPRESS = 1'b0;
  localparam logic MODE_COMPRESS   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : pin_pkg

// File: rtl/pin_codec_slice.sv
// pin_codec_slice: combinational processing of one STEP-bit mask slice.
//   mode_i : 0 = decompress (scatter), 1 = compress (gather)
//   data_i : captured source bits
//   mask_i : captured pin selection mask
//   base_i : bit position of the slice's lowest mask bit
//   idx_i  : running source (scatter) / destination (gather) index
//   idx_o  : index after this slice (idx_i + set bits in the slice)
//   wr_o   : result bits written by this slice, to be ORed into the result
module pin_codec_slice
  import pin_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  parameter int IW    = $clog2(WIDTH + 1)
) (
  input  logic             mode_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] mask_i,
  input  logic [IW-1:0]    base_i,
  input  logic [IW-1:0]    idx_i,
  output logic [IW-1:0]    idx_o,
  output logic [WIDTH-1:0] wr_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [IW-1:0]    idx_v;
  logic [IW-1:0]    pos_v;
  logic [WIDTH-1:0] wr_v;
  logic             mask_bit_v;
  logic             data_bit_v;

  // Walk the slice LSB first; single-bit picks use shifted one-hot masks so
  // an index equal to WIDTH simply selects nothing instead of going out of range.
  always_comb begin
    idx_v      = idx_i;
    pos_v      = base_i;
    wr_v       = '0;
    mask_bit_v = 1'b0;
    data_bit_v = 1'b0;
    for (int j = 0; j < STEP; j++) begin
      pos_v      = base_i + IW'(j);
      mask_bit_v = |(mask_i & (ONE << pos_v));
      if (mask_bit_v) begin
        if (mode_i == MODE_COMPRESS) begin
          data_bit_v = |(data_i & (ONE << pos_v));
          wr_v       = wr_v | (data_bit_v ? (ONE << idx_v) : '0);
        end else begin
          data_bit_v = |(data_i & (ONE << idx_v));
          wr_v       = wr_v | (data_bit_v ? (ONE << pos_v) : '0);
        end
        idx_v = idx_v + IW'(1);
      end else begin
        idx_v = idx_v;
      end
    end
    idx_o = idx_v;
    wr_o  = wr_v;
  end

endmodule : pin_codec_slice

// File: rtl/pin_codec.sv
// pin_codec: multi-cycle bit scatter/gather engine (STEP mask bits per cycle).
//   clk       : sole clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  / in_ready  : request handshake (in_ready only in IDLE)
//   mode      : 0 = decompress (scatter), 1 = compress (gather)
//   data/mask : source bits and pin selection mask, captured on accept
//   out_valid / out_ready : result handshake (out_valid only in DONE)
//   result    : operation result, held while out_valid && !out_ready
//   count     : popcount(mask), only when PIN_CODEC_COUNT_EN is defined
// Optional feature macro: PIN_CODEC_COUNT_EN
module pin_codec
  import pin_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         mode,
  input  logic [WIDTH-1:0]             data,
  input  logic [WIDTH-1:0]             mask,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             result
`ifdef PIN_CODEC_COUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0]   count
`endif
);

  localparam int IW = $clog2(WIDTH + 1);

  if ((STEP < 1) || (WIDTH < 4) || (WIDTH > 64) || ((WIDTH % STEP) != 0)) begin : g_bad_cfg
    $error("pin_codec: WIDTH must be 4..64 and a multiple of STEP");
  end

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    pos_q, pos_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [IW-1:0]    slice_idx;
  logic [WIDTH-1:0] slice_wr;

  pin_codec_slice #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .IW    (IW)
  ) u_slice (
    .mode_i (mode_q),
    .data_i (data_q),
    .mask_i (mask_q),
    .base_i (pos_q),
    .idx_i  (idx_q),
    .idx_o  (slice_idx),
    .wr_o   (slice_wr)
  );

  // Next-state and datapath update; RUN length depends only on the slice
  // position, never on how many mask bits are set.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    data_d   = data_q;
    mask_d   = mask_q;
    idx_d    = idx_q;
    pos_d    = pos_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d   = mode;
          data_d   = data;
          mask_d   = mask;
          idx_d    = '0;
          pos_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        result_d = result_q | slice_wr;
        idx_d    = slice_idx;
        if (pos_q == IW'(WIDTH - STEP)) begin
          pos_d   = '0;
          state_d = DONE;
        end else begin
          pos_d   = pos_q + IW'(STEP);
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      data_q   <= '0;
      mask_q   <= '0;
      idx_q    <= '0;
      pos_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      pos_q    <= pos_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

`ifdef PIN_CODEC_COUNT_EN
  // After the last slice the running index equals popcount(mask).
  assign count = idx_q;
`endif

endmodule : pin_codec

// File: tb/tb_pin_codec.sv
// tb_pin_codec: directed self-checking bench for pin_codec (WIDTH=16, STEP=4).
module tb_pin_codec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [15:0] data;
  logic [15:0] mask;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
`ifdef PIN_CODEC_COUNT_EN
  logic [4:0]  count;
`endif

  int tests = 0;
  int fails = 0;

  pin_codec #(.WIDTH(16), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .data      (data),
    .mask      (mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef PIN_CODEC_COUNT_EN
    ,
    .count     (count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called right after the accept edge; counts edges until out_valid (bounded).
  task automatic wait_valid(input string tag);
    int n;
    n = 1;
    while ((out_valid !== 1'b1) && (n < 20)) begin
      step();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd5);
  endtask

  task automatic run_op(input string tag, input logic m, input logic [15:0] d,
                        input logic [15:0] mk, input logic [15:0] exp, input int exp_cnt);
    mode = m; data = d; mask = mk; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    data = ~d; mask = ~mk; mode = ~m;   // must be ignored after accept
    check({tag, " busy"}, {63'd0, in_ready}, 64'd0);
    wait_valid(tag);
    check({tag, " result"}, {48'd0, result}, {48'd0, exp});
`ifdef PIN_CODEC_COUNT_EN
    check({tag, " count"}, {59'd0, count}, 64'(exp_cnt));
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " back idle"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    int  seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mode = 1'b0; data = 16'h0000; mask = 16'h0000;
    step();
    step();
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset result", {48'd0, result}, 64'd0);
`ifdef PIN_CODEC_COUNT_EN
    check("reset count", {59'd0, count}, 64'd0);
`endif
    rst_n = 1'b1;
    step();
    check("in_ready after reset", {63'd0, in_ready}, 64'd1);

    // Basic scatter/gather and boundary masks
    run_op("scatter 5145", 1'b0, 16'h000B, 16'h5145, 16'h0105, 6);
    run_op("gather 5145",  1'b1, 16'h0105, 16'h5145, 16'h000B, 6);
    run_op("scatter ones", 1'b0, 16'hA5C3, 16'hFFFF, 16'hA5C3, 16);
    run_op("gather ones",  1'b1, 16'hA5C3, 16'hFFFF, 16'hA5C3, 16);
    run_op("scatter zero", 1'b0, 16'hA5C3, 16'h0000, 16'h0000, 0);
    run_op("gather zero",  1'b1, 16'hA5C3, 16'h0000, 16'h0000, 0);
    run_op("gather hi",    1'b1, 16'hF0F0, 16'hFF00, 16'h00F0, 8);
    run_op("scatter hi",   1'b0, 16'h00F0, 16'hFF00, 16'hF000, 8);

    // Backpressure: hold out_ready low for 10 cycles
    mode = 1'b0; data = 16'h000B; mask = 16'h5145; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      check("bp result", {48'd0, result}, 64'h0105);
      check("bp out_valid", {63'd0, out_valid}, 64'd1);
      check("bp in_ready", {63'd0, in_ready}, 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp release", {62'd0, out_valid, in_ready}, 64'd1);

    // in_valid held with new data during RUN
    mode = 1'b0; data = 16'h000B; mask = 16'h5145; in_valid = 1'b1;
    step();
    mode = 1'b1; data = 16'hA5C3; mask = 16'hFFFF;
    wait_valid("hold first");
    check("hold first result", {48'd0, result}, 64'h0105);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hold idle", {62'd0, out_valid, in_ready}, 64'd1);
    step();   // second request accepted here
    in_valid = 1'b0;
    check("hold second busy", {63'd0, in_ready}, 64'd0);
    wait_valid("hold second");
    check("hold second result", {48'd0, result}, 64'hA5C3);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset in the second RUN cycle
    mode = 1'b0; data = 16'h000B; mask = 16'h5145; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check("abort out_valid", {63'd0, out_valid}, 64'd0);
    check("abort result", {48'd0, result}, 64'd0);
    check("abort in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid !== 1'b0) seen = 1;
    end
    check("no stale result", 64'(seen), 64'd0);
    run_op("after abort", 1'b1, 16'h0105, 16'h5145, 16'h000B, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pin_codec
